cmp_sort_ctrl: RTL and testbench

Sequencing controller that sorts a small buffer of unsigned values in ascending order by time-sharing one external `comparator4bit` instance (A/B in; gtA/gtB/AeqB out). Values are loaded through a valid/ready port and sorted in place by bubble sort, one compare per cycle, with early exit. The sorted buffer is then read back through a combinational read port. The block sits between a producer of samples and any consumer that needs ordered data, such as a median or rank stage.

---
 rtl/cmp_sort_ctrl.sv | 149 ++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort controller for a small buffer that time-shares one external comparator.
// Values load through valid/ready, sort in place one compare per cycle, read back combinationally.
module cmp_sort_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic [W-1:0]         load_data,
  output logic                 load_ready,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           swaps,
  input  logic [$clog2(N)-1:0] rd_idx,
  output logic [W-1:0]         rd_data,
  output logic [W-1:0]         cmp_a,
  output logic [W-1:0]         cmp_b,
  input  logic                 cmp_gtA,
  input  logic                 cmp_gtB,
  input  logic                 cmp_eq,
  output logic                 cmp_err
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e              state_q, state_d;
  logic [N-1:0][W-1:0] mem_q, mem_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IW-1:0]       p_q, p_d, i_q, i_d;
  logic [IW-1:0]       i_nxt, last_i;
  logic                flag_q, flag_d, flag_now;
  logic [7:0]          swaps_q, swaps_d;
  logic                err_q, err_d;
  logic                full;

  assign full   = (count_q == CW'(N));
  assign i_nxt  = i_q + IW'(1);
  // Each pass settles one more entry at the top, so the last index shrinks with p.
  assign last_i = IW'(N - 2) - p_q;

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    count_d    = count_q;
    p_d        = p_q;
    i_d        = i_q;
    flag_d     = flag_q;
    swaps_d    = swaps_q;
    err_d      = err_q;
    flag_now   = flag_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cmp_a      = '0;
    cmp_b      = '0;

    case (state_q)
      StIdle: begin
        load_ready = !full;
        // A load in the same cycle as start wins; start is dropped.
        if (load_valid && !full) begin
          mem_d[count_q[IW-1:0]] = load_data;
          count_d                = count_q + CW'(1);
        end else if (start && full) begin
          swaps_d = '0;
          p_d     = '0;
          i_d     = '0;
          flag_d  = 1'b0;
          state_d = StSort;
        end
      end

      StSort: begin
        busy  = 1'b1;
        cmp_a = mem_q[i_q];
        cmp_b = mem_q[i_nxt];
        if (!$onehot({cmp_gtA, cmp_gtB, cmp_eq})) begin
          err_d = 1'b1;
        end
        if (cmp_gtA) begin
          mem_d[i_q]   = mem_q[i_nxt];
          mem_d[i_nxt] = mem_q[i_q];
          if (swaps_q != 8'hFF) begin
            swaps_d = swaps_q + 8'd1;
          end
          flag_now = 1'b1;
        end
        if (i_q == last_i) begin
          if (!flag_now || (p_q == IW'(N - 2))) begin
            state_d = StDone;
          end else begin
            p_d    = p_q + IW'(1);
            i_d    = '0;
            flag_d = 1'b0;
          end
        end else begin
          i_d    = i_nxt;
          flag_d = flag_now;
        end
      end

      StDone: begin
        done    = 1'b1;
        count_d = '0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mem_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
      i_q     <= '0;
      flag_q  <= 1'b0;
      swaps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      count_q <= count_d;
      p_q     <= p_d;
      i_q     <= i_d;
      flag_q  <= flag_d;
      swaps_q <= swaps_d;
      err_q   <= err_d;
    end
  end

  assign swaps   = swaps_q;
  assign cmp_err = err_q;

  // Out-of-range addresses only exist when N is not a power of two.
  if ((1 << IW) > N) begin : g_rd_guard
    assign rd_data = (int'(rd_idx) < int'(N)) ? mem_q[rd_idx] : '0;
  end else begin : g_rd_direct
    assign rd_data = mem_q[rd_idx];
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Scoreboarded bench for cmp_sort_ctrl: an array-level bubble-sort model queues the
// expected per-compare contents and results; a monitor pops and compares them.
module tb_cmp_sort_ctrl;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = $clog2(N);

  typedef logic [N*W-1:0] buf_t;
  typedef struct {
    buf_t contents;
    int   idx;
  } snap_t;
  typedef struct {
    buf_t contents;
    int   swaps;
    int   cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    swaps;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  cmp_a;
  logic [W-1:0]  cmp_b;
  logic          cmp_gtA;
  logic          cmp_gtB;
  logic          cmp_eq;
  logic          cmp_err;
  logic          fault;

  snap_t        snap_q[$];
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] seen[N];

  cmp_sort_ctrl #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .swaps      (swaps),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_gtA    (cmp_gtA),
    .cmp_gtB    (cmp_gtB),
    .cmp_eq     (cmp_eq),
    .cmp_err    (cmp_err)
  );

  always #10 clk = ~clk;

  // External comparator; fault forces a non-one-hot result with gtA set.
  always_comb begin
    cmp_gtA = cmp_a > cmp_b;
    cmp_gtB = cmp_b > cmp_a;
    cmp_eq  = cmp_a == cmp_b;
    if (fault) begin
      cmp_gtA = 1'b1;
      cmp_gtB = 1'b0;
      cmp_eq  = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic buf_t pack(input int a[N]);
    buf_t r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'(a[k]);
    return r;
  endfunction

  function automatic buf_t pack_seen();
    buf_t r;
    for (int k = 0; k < N; k++) r[k*W +: W] = seen[k];
    return r;
  endfunction

  // Reference: textbook bubble sort with early exit, recording each compare.
  task automatic model_sort(input int v[N]);
    int    a[N];
    int    sw;
    int    c;
    int    t;
    bit    f;
    snap_t s;
    exp_t  e;
    a  = v;
    sw = 0;
    c  = 0;
    for (int p = 0; p <= N - 2; p++) begin
      f = 1'b0;
      for (int i = 0; i <= N - 2 - p; i++) begin
        s.contents = pack(a);
        s.idx      = i;
        snap_q.push_back(s);
        c++;
        if (a[i] > a[i+1]) begin
          t      = a[i];
          a[i]   = a[i+1];
          a[i+1] = t;
          sw++;
          f = 1'b1;
        end
      end
      if (!f) break;
    end
    e.contents = pack(a);
    e.swaps    = (sw > 255) ? 255 : sw;
    e.cycles   = c;
    exp_q.push_back(e);
  endtask

  // Monitor: sweeps the read port each negedge, then checks SORT and DONE cycles.
  initial begin
    logic  prev_busy;
    logic  prev_done;
    int    run;
    snap_t s;
    exp_t  e;
    buf_t  got;
    prev_busy = 1'b0;
    prev_done = 1'b0;
    run       = 0;
    rd_idx    = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        rd_idx = IW'(k);
        #1;
        seen[k] = rd_data;
      end
      got = pack_seen();
      if (rst) begin
        run       = 0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy) begin
          run++;
          check("sort_load_ready_low", load_ready, 0);
          if (snap_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sort_cycle: got extra SORT cycle, expected none");
          end else begin
            s = snap_q.pop_front();
            check("partial_contents", got, s.contents);
            check("cmp_a_operand", cmp_a, s.contents[s.idx*W +: W]);
            check("cmp_b_operand", cmp_b, s.contents[(s.idx+1)*W +: W]);
          end
        end else begin
          check("cmp_a_idle", cmp_a, 0);
          check("cmp_b_idle", cmp_b, 0);
        end
        if (done) begin
          check("done_busy_exclusive", busy, 0);
          check("done_after_sort", prev_busy, 1);
          check("done_single_pulse", prev_done, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_pulse: got unexpected done, expected none");
          end else begin
            e = exp_q.pop_front();
            check("sorted_contents", got, e.contents);
            check("swaps", swaps, e.swaps);
            check("compare_cycles", run, e.cycles);
          end
          run = 0;
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #5;
  endtask

  task automatic load_one(input int v);
    load_valid = 1'b1;
    load_data  = W'(v);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic load_all(input int v[N], input int cnt);
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      load_one(v[k]);
    end
  endtask

  task automatic pulse_start(input bit expect_sort, input int v[N]);
    start = 1'b1;
    if (expect_sort) model_sort(v);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      sample();
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (got) begin
      sample();
      check("load_ready_after_done", load_ready, 1);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic run_sort(input int v[N]);
    load_all(v, N);
    pulse_start(1'b1, v);
    sample();
    check("busy_after_start", busy, 1);
    wait_done();
  endtask

  initial begin
    int v[N];
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    start      = 1'b0;
    fault      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    check("reset_load_ready", load_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_swaps", swaps, 0);
    check("reset_cmp_err", cmp_err, 0);
    check("reset_contents", pack_seen(), 0);

    v = '{9, 1, 4, 1};
    run_sort(v);
    check("cmp_err_clean", cmp_err, 0);
    v = '{1, 4, 5, 9};
    run_sort(v);
    v = '{15, 9, 6, 0};
    run_sort(v);

    // Start ignored until the buffer is full, and ignored alongside an accepted load.
    v = '{7, 3, 12, 3};
    load_all(v, 3);
    pulse_start(1'b0, v);
    sample();
    check("start_not_full", busy, 0);
    load_valid = 1'b1;
    load_data  = W'(v[3]);
    start      = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    start      = 1'b0;
    sample();
    check("start_with_load", busy, 0);
    check("full_holds_ready", load_ready, 0);
    pulse_start(1'b1, v);
    wait_done();

    // Asynchronous reset in the second SORT cycle.
    v = '{8, 2, 6, 4};
    load_all(v, N);
    start = 1'b1;
    model_sort(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_load_ready", load_ready, 1);
    snap_q.delete();
    exp_q.delete();
    sample();
    check("abort_contents_cleared", pack_seen(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      sample();
      check("no_done_after_abort", done, 0);
    end

    // Faulty comparator during the first SORT cycle (15 vs 9, swap expected anyway).
    v = '{15, 9, 6, 0};
    load_all(v, N);
    start = 1'b1;
    model_sort(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    fault = 1'b1;
    @(posedge clk);
    #1;
    fault = 1'b0;
    sample();
    check("cmp_err_set", cmp_err, 1);
    wait_done();
    check("cmp_err_after_done", cmp_err, 1);
    v = '{2, 11, 5, 5};
    run_sort(v);
    check("cmp_err_sticky", cmp_err, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    check("cmp_err_reset", cmp_err, 0);

    // Randomised buffers; alternate narrow ranges to exercise duplicates.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < N; k++) begin
        v[k] = (r % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      end
      run_sort(v);
    end
    check("cmp_err_final", cmp_err, 0);
    check("scoreboard_drained", snap_q.size() + exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
